// File: rtl/rv32_instruction_fetch.sv
// rv32_instruction_fetch: sequential instruction fetch front end.
// Issues word read requests into a fixed-latency instruction memory.
// Tags each returned word with its PC and buffers it in a show-ahead prefetch FIFO.
// Hands instructions to decode over valid/ready.
// A redirect loads a new PC, flushes the FIFO and invalidates in-flight responses.
// Optional build macro: RV32_IFETCH_STATS_EN adds fetched/dropped/stall counters.
module rv32_instruction_fetch #(
    parameter int unsigned NumWords  = 8096,
    parameter int unsigned AddrWidth = (NumWords <= 1) ? 1 : $clog2(NumWords),
    parameter int unsigned Latency   = 1,
    parameter int unsigned FifoDepth = 4,
    parameter logic [31:0] ResetPc   = 32'h0000_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    input  logic [31:0]          mem_rdata_i,
    input  logic                 redirect_i,
    input  logic [31:0]          redirect_pc_i,
    output logic                 instr_valid_o,
    input  logic                 instr_ready_i,
    output logic [31:0]          instr_o,
    output logic [31:0]          instr_pc_o
`ifdef RV32_IFETCH_STATS_EN
    ,
    output logic [31:0]          stat_fetched_o,
    output logic [31:0]          stat_dropped_o,
    output logic [31:0]          stat_stall_o
`endif
);

    localparam int unsigned PtrW = (FifoDepth <= 2) ? 1 : $clog2(FifoDepth);
    localparam int unsigned CntW = PtrW + 2;

    // Fetch PC and flush epoch
    logic [31:0] pc_q, pc_d;
    logic        epoch_q, epoch_d;

    // In-flight pipe: one stage per cycle of memory latency
    logic [Latency-1:0] pipe_v_q;
    logic [Latency-1:0] pipe_e_q;
    logic [31:0]        pipe_pc_q [Latency];

    // Prefetch FIFO
    logic [31:0]     fifo_data_q [FifoDepth];
    logic [31:0]     fifo_pc_q   [FifoDepth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q, count_d;

    // Combinational control
    logic [CntW-1:0] inflight_cnt;
    logic            credit_ok;
    logic            req;
    logic            resp_hit;
    logic            push;
    logic            pop;
    logic            fifo_empty;

    // Count outstanding requests still travelling through the memory pipe
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < int'(Latency); i++) begin
            inflight_cnt = inflight_cnt + CntW'(pipe_v_q[i]);
        end
    end

    // Credit, handshake and FIFO push/pop decisions; reset gates the request
    always_comb begin
        credit_ok  = ((CntW'(count_q) + inflight_cnt) < CntW'(FifoDepth));
        req        = rst_ni && !redirect_i && credit_ok;
        resp_hit   = pipe_v_q[Latency-1] && (pipe_e_q[Latency-1] == epoch_q);
        push       = resp_hit && !redirect_i;
        fifo_empty = (count_q == '0);
        pop        = !fifo_empty && !redirect_i && instr_ready_i;
    end

    assign mem_req_o     = req;
    assign mem_we_o      = 1'b0;
    assign mem_addr_o    = pc_q[AddrWidth+1:2];
    assign instr_valid_o = !fifo_empty && !redirect_i;
    assign instr_o       = fifo_empty ? 32'd0 : fifo_data_q[rd_ptr_q];
    assign instr_pc_o    = fifo_empty ? 32'd0 : fifo_pc_q[rd_ptr_q];

    // Next PC / epoch: redirect wins over sequential advance
    always_comb begin
        pc_d    = pc_q;
        epoch_d = epoch_q;
        if (redirect_i) begin
            pc_d    = redirect_pc_i & ~32'd3;
            epoch_d = ~epoch_q;
        end else if (req) begin
            pc_d = pc_q + 32'd4;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC and epoch registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q    <= ResetPc & ~32'd3;
            epoch_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            epoch_q <= epoch_d;
        end
    end

    // In-flight pipe shift; a redirect kills every stage so epoch only guards the last one
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_v_q <= '0;
            pipe_e_q <= '0;
            for (int i = 0; i < int'(Latency); i++) begin
                pipe_pc_q[i] <= 32'd0;
            end
        end else begin
            pipe_v_q[0]  <= req;
            pipe_e_q[0]  <= epoch_q;
            pipe_pc_q[0] <= pc_q;
            for (int i = 1; i < int'(Latency); i++) begin
                pipe_v_q[i]  <= redirect_i ? 1'b0 : pipe_v_q[i-1];
                pipe_e_q[i]  <= pipe_e_q[i-1];
                pipe_pc_q[i] <= pipe_pc_q[i-1];
            end
        end
    end

    // FIFO occupancy next state
    always_comb begin
        count_d = count_q;
        if (redirect_i) begin
            count_d = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + {{PtrW{1'b0}}, 1'b1};
                2'b01:   count_d = count_q - {{PtrW{1'b0}}, 1'b1};
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO pointers and occupancy; a redirect empties the buffer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (redirect_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + {{(PtrW-1){1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + {{(PtrW-1){1'b0}}, 1'b1};
            end
            count_q <= count_d;
        end
    end

    // FIFO storage: capture returned word with the PC it was fetched from
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(FifoDepth); i++) begin
                fifo_data_q[i] <= 32'd0;
                fifo_pc_q[i]   <= 32'd0;
            end
        end else if (push) begin
            fifo_data_q[wr_ptr_q] <= mem_rdata_i;
            fifo_pc_q[wr_ptr_q]   <= pipe_pc_q[Latency-1];
        end
    end

`ifdef RV32_IFETCH_STATS_EN
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        stale;
    logic [31:0] fetched_q, dropped_q, stall_q;

    // FILL/RUN tracking of FIFO emptiness
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (redirect_i) begin
                    state_d = ST_FILL;
                end else if (push) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_RUN: begin
                if (redirect_i) begin
                    state_d = ST_FILL;
                end else if (pop && !push && (count_q == {{PtrW{1'b0}}, 1'b1})) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    assign stale = pipe_v_q[Latency-1] && (pipe_e_q[Latency-1] != epoch_q);

    // Statistics counters: handshakes, discarded responses, starved cycles
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetched_q <= 32'd0;
            dropped_q <= 32'd0;
            stall_q   <= 32'd0;
        end else begin
            if (pop) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if (redirect_i) begin
                dropped_q <= dropped_q + 32'(inflight_cnt);
            end else if (stale) begin
                dropped_q <= dropped_q + 32'd1;
            end
            if (instr_ready_i && (state_q == ST_FILL)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign stat_fetched_o = fetched_q;
    assign stat_dropped_o = dropped_q;
    assign stat_stall_o   = stall_q;
`endif

endmodule
